sr_driver: RTL

Command-side companion to the team's clocked SR flip-flop bank: it accepts target words over a valid/ready handshake and issues per-bit set/reset pulses to a WIDTH-bit bank of SR flops. After a settle window it reads the bank's `q` outputs back and reports completion and any mismatch. It guarantees that the illegal `s=r=1` command is never produced and drives the bank to a known all-zero state after reset.

---
 rtl/sr_pkg.sv | 24 ++
 rtl/sr_driver_if.sv | 42 ++++
 rtl/sr_cmd_encode.sv | 20 ++
 rtl/sr_driver.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and constants for the SR flop bank command driver.
package sr_pkg;

    // Driver sequencing states
    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        DRIVE  = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4
    } sr_drv_state_t;

    // Per-bit command, packed in {s,r} order
    typedef struct packed {
        logic s;
        logic r;
    } sr_cmd_t;

    localparam sr_cmd_t SR_HOLD    = 2'b00;
    localparam sr_cmd_t SR_RST     = 2'b01;
    localparam sr_cmd_t SR_SET     = 2'b10;
    localparam sr_cmd_t SR_ILLEGAL = 2'b11;

endpackage

// File: rtl/sr_driver_if.sv
// Handshake, command and readback signals between the driver and its environment.
interface sr_driver_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q_fb;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] mismatch;

    // Environment side: offers words, returns the bank readback
    modport master (
        output in_valid,
        output in_data,
        output q_fb,
        input  in_ready,
        input  s,
        input  r,
        input  done,
        input  err,
        input  mismatch
    );

    // Driver side
    modport slave (
        input  in_valid,
        input  in_data,
        input  q_fb,
        output in_ready,
        output s,
        output r,
        output done,
        output err,
        output mismatch
    );

endinterface

// File: rtl/sr_cmd_encode.sv
// Single-bit (target, shadow) to {s,r} encoder; can never emit s=r=1.
module sr_cmd_encode
    import sr_pkg::*;
(
    input  logic    target,
    input  logic    shadow,
    output sr_cmd_t cmd_c
);

    // Set when rising, reset when falling, hold otherwise
    always_comb begin
        cmd_c = SR_HOLD;
        if (target && !shadow) begin
            cmd_c = SR_SET;
        end else if (!target && shadow) begin
            cmd_c = SR_RST;
        end
    end

endmodule

// File: rtl/sr_driver.sv
// Drives an SR flop bank toward accepted target words and verifies it by readback.
module sr_driver
    import sr_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned PULSE_CYC  = 1,
    parameter int unsigned SETTLE_CYC = 1
) (
    input logic        clk,
    input logic        rst,
    sr_driver_if.slave bus
);

    localparam int unsigned CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    sr_drv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mismatch_q, mismatch_d;

    sr_cmd_t          cmd_c [WIDTH];
    logic [WIDTH-1:0] set_c;
    logic [WIDTH-1:0] clr_c;
    logic             accept_c;

    // Per-bit command encoders against the believed bank value
    for (genvar i = 0; i < WIDTH; i++) begin : g_enc
        sr_cmd_encode u_enc (
            .target (bus.in_data[i]),
            .shadow (shadow_q[i]),
            .cmd_c  (cmd_c[i])
        );
        assign set_c[i] = cmd_c[i].s;
        assign clr_c[i] = cmd_c[i].r;
    end

    assign accept_c = bus.in_valid & ready_q;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= CNT_W'(PULSE_CYC);
            shadow_q   <= '0;
            s_q        <= '0;
            r_q        <= '1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mismatch_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            s_q        <= s_d;
            r_q        <= r_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Next-state and next-output logic; one counter times INIT, DRIVE and SETTLE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        s_d        = s_q;
        r_d        = r_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mismatch_d = mismatch_q;

        case (state_q)
            INIT: begin
                if (cnt_q == '0) begin
                    r_d     = '0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            IDLE: begin
                if (accept_c) begin
                    s_d        = set_c;
                    r_d        = clr_c;
                    shadow_d   = bus.in_data;
                    mismatch_d = '0;
                    ready_d    = 1'b0;
                    if ((set_c | clr_c) != '0) begin
                        cnt_d   = CNT_W'(PULSE_CYC - 1);
                        state_d = DRIVE;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    s_d     = '0;
                    r_d     = '0;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CHECK: begin
                mismatch_d = bus.q_fb ^ shadow_q;
                err_d      = |(bus.q_fb ^ shadow_q);
                done_d     = 1'b1;
                ready_d    = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                s_d     = '0;
                r_d     = '1;
                ready_d = 1'b0;
                cnt_d   = CNT_W'(PULSE_CYC);
                state_d = INIT;
            end
        endcase
    end

    assign bus.in_ready = ready_q;
    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.mismatch = mismatch_q;

    // The bank must never see set and reset together
    a_no_illegal: assert property (@(posedge clk) (s_q & r_q) == '0);

endmodule
